serial_adder_controller: RTL



---
 rtl/serial_adder_controller.sv | 113 +++++++++++
 1 files changed

// File: rtl/serial_adder_controller.sv
// Bit-serial N-bit unsigned adder with start/done handshake.
// One bit pair per clock, LSB first, through two half-adder cells and an OR.

module one_bit_half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b;
    assign carry = a & b;
endmodule

module serial_adder_controller #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N:0]   result
);
    localparam int unsigned CW = $clog2(N) + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t         state;
    logic [N-1:0]   a_sr;
    logic [N-1:0]   b_sr;
    logic [N-1:0]   sum_sr;
    logic [N-1:0]   sum_nxt;
    logic           carry_ff;
    logic [CW-1:0]  cnt;
    logic           ha0_sum;
    logic           ha0_carry;
    logic           s;
    logic           ha1_carry;
    logic           c;

    one_bit_half_adder u_ha0 (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .sum   (ha0_sum),
        .carry (ha0_carry)
    );

    one_bit_half_adder u_ha1 (
        .a     (ha0_sum),
        .b     (carry_ff),
        .sum   (s),
        .carry (ha1_carry)
    );

    assign c = ha0_carry | ha1_carry;

    // New sum bit enters at the MSB; shift form keeps N=1 legal.
    assign sum_nxt = (N'(s) << (N - 1)) | (sum_sr >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            sum_sr   <= '0;
            carry_ff <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr     <= a;
                        b_sr     <= b;
                        sum_sr   <= '0;
                        carry_ff <= 1'b0;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    sum_sr   <= sum_nxt;
                    a_sr     <= a_sr >> 1;
                    b_sr     <= b_sr >> 1;
                    carry_ff <= c;
                    cnt      <= cnt + CW'(1);
                    if (cnt == CW'(N - 1)) begin
                        result <= {c, sum_nxt};
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
